// File: rtl/lfsr_pkg.sv
// Shared types and the single-step LFSR transfer function used by the
// parallel generator.
package lfsr_pkg;

    // Widest LFSR the step function can carry; callers zero-extend to this.
    localparam int unsigned LFSR_MAX_N = 64;

    typedef enum logic {
        LFSR_FIBONACCI = 1'b0,
        LFSR_GALOIS    = 1'b1
    } lfsr_form_e;

    typedef struct packed {
        logic                  out_bit;
        logic [LFSR_MAX_N-1:0] state;
    } lfsr_step_t;

    // One LFSR step on an n-bit register held in the LSBs of a max-width
    // vector. Bits at and above n must be zero on entry and stay zero.
    function automatic lfsr_step_t lfsr_step(
        input logic [LFSR_MAX_N-1:0] state,
        input logic [LFSR_MAX_N-1:0] taps,
        input int unsigned           n,
        input lfsr_form_e            form
    );
        lfsr_step_t r;
        logic       fb;
        r.out_bit = state[0];
        fb        = ^(state & taps);
        if (form == LFSR_GALOIS) begin
            r.state = (state >> 1) ^ ({LFSR_MAX_N{state[0]}} & taps);
        end else begin
            r.state = (state >> 1) | (fb ? (LFSR_MAX_N'(1) << (n - 1)) : '0);
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational W-step unroll of the LFSR: produces the output word
// (bit 0 first) and the state after W steps.
module lfsr_advance
    import lfsr_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned W      = 1,
    parameter bit          GALOIS = 1'b0
) (
    input  logic [N-1:0] state_i,
    input  logic [N-1:0] taps_i,
    output logic [W-1:0] word_o,
    output logic [N-1:0] next_state_o
);

    localparam lfsr_form_e FORM = GALOIS ? LFSR_GALOIS : LFSR_FIBONACCI;

    logic [LFSR_MAX_N-1:0] chain_s;
    logic [LFSR_MAX_N-1:0] taps_ext;
    lfsr_step_t            step_r;

    always_comb begin
        chain_s          = '0;
        chain_s[N-1:0]   = state_i;
        taps_ext         = '0;
        taps_ext[N-1:0]  = taps_i;
        step_r           = '0;
        word_o           = '0;
        for (int unsigned k = 0; k < W; k++) begin
            step_r    = lfsr_step(chain_s, taps_ext, N, FORM);
            word_o[k] = step_r.out_bit;
            chain_s   = step_r.state;
        end
        next_state_o = chain_s[N-1:0];
    end

endmodule

// File: rtl/lfsr_parallel_gen.sv
// Parallel LFSR bit generator: W bits per beat on a valid/ready stream,
// with optional runtime taps/seed loading and all-zero lock-up flag.
module lfsr_parallel_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned N               = 8,
    parameter int unsigned W               = 1,
    parameter logic [N-1:0] START_VALUE    = N'(8'b00000001),
    parameter logic [N-1:0] TAPS           = N'(8'b00000011),
    parameter bit          GALOIS          = 1'b0,
    parameter bit          VARIABLE_CONFIG = 1'b0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_config_i,
    input  logic [N-1:0] taps_i,
    input  logic [N-1:0] start_value_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         lockup_o
);

    localparam logic [N-1:0] RESET_STATE = VARIABLE_CONFIG ? '0 : START_VALUE;

    logic [N-1:0] state_q, state_d;
    logic [N-1:0] taps_q, taps_d;
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         lockup_q, lockup_d;

    logic [W-1:0] beat_word;
    logic [N-1:0] beat_next;
    logic         load;

    lfsr_advance #(
        .N      (N),
        .W      (W),
        .GALOIS (GALOIS)
    ) u_advance (
        .state_i      (state_q),
        .taps_i       (taps_q),
        .word_o       (beat_word),
        .next_state_o (beat_next)
    );

    assign load = VARIABLE_CONFIG && load_config_i;

    // Load wins over the handshake; a word offered in the same cycle is
    // still considered accepted downstream, but nothing new is produced.
    always_comb begin
        state_d  = state_q;
        taps_d   = taps_q;
        data_d   = data_q;
        valid_d  = valid_q;
        lockup_d = lockup_q;
        if (load) begin
            taps_d   = taps_i;
            state_d  = start_value_i;
            valid_d  = 1'b0;
            lockup_d = (start_value_i == '0);
        end else if (!valid_q || ready_i) begin
            data_d   = beat_word;
            valid_d  = 1'b1;
            state_d  = beat_next;
            lockup_d = (beat_next == '0);
        end
        if (!VARIABLE_CONFIG) begin
            taps_d = TAPS;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= RESET_STATE;
            taps_q   <= TAPS;
            data_q   <= '0;
            valid_q  <= 1'b0;
            lockup_q <= (RESET_STATE == '0);
        end else begin
            state_q  <= state_d;
            taps_q   <= taps_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_parallel_gen.sv
// Bench for lfsr_parallel_gen: five instances (Fibonacci/Galois, W=8/W=1,
// one runtime-configurable) compared each cycle against an arithmetic model.
module tb_lfsr_parallel_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i;
    logic [4:0] rdy;
    logic       load_v;
    logic [7:0] taps_v, seed_v;
    logic       load_n;
    logic [7:0] taps_n, seed_n;
    logic [7:0] d0, d2, d4;
    logic       d1, d3;
    logic [4:0] vld, lck;

    lfsr_parallel_gen #(.N(8), .W(8), .START_VALUE(8'h01), .TAPS(8'h03), .GALOIS(1'b0), .VARIABLE_CONFIG(1'b0)) u_f8 (
        .clk_i(clk), .reset_i(reset_i), .load_config_i(load_n), .taps_i(taps_n), .start_value_i(seed_n),
        .ready_i(rdy[0]), .data_o(d0), .valid_o(vld[0]), .lockup_o(lck[0]));
    lfsr_parallel_gen #(.N(8), .W(1), .START_VALUE(8'h01), .TAPS(8'h03), .GALOIS(1'b0), .VARIABLE_CONFIG(1'b0)) u_f1 (
        .clk_i(clk), .reset_i(reset_i), .load_config_i(load_n), .taps_i(taps_n), .start_value_i(seed_n),
        .ready_i(rdy[1]), .data_o(d1), .valid_o(vld[1]), .lockup_o(lck[1]));
    lfsr_parallel_gen #(.N(8), .W(8), .START_VALUE(8'h01), .TAPS(8'h03), .GALOIS(1'b1), .VARIABLE_CONFIG(1'b0)) u_g8 (
        .clk_i(clk), .reset_i(reset_i), .load_config_i(load_n), .taps_i(taps_n), .start_value_i(seed_n),
        .ready_i(rdy[2]), .data_o(d2), .valid_o(vld[2]), .lockup_o(lck[2]));
    lfsr_parallel_gen #(.N(8), .W(1), .START_VALUE(8'h01), .TAPS(8'h03), .GALOIS(1'b1), .VARIABLE_CONFIG(1'b0)) u_g1 (
        .clk_i(clk), .reset_i(reset_i), .load_config_i(load_n), .taps_i(taps_n), .start_value_i(seed_n),
        .ready_i(rdy[3]), .data_o(d3), .valid_o(vld[3]), .lockup_o(lck[3]));
    lfsr_parallel_gen #(.N(8), .W(8), .START_VALUE(8'h01), .TAPS(8'h03), .GALOIS(1'b0), .VARIABLE_CONFIG(1'b1)) u_v8 (
        .clk_i(clk), .reset_i(reset_i), .load_config_i(load_v), .taps_i(taps_v), .start_value_i(seed_v),
        .ready_i(rdy[4]), .data_o(d4), .valid_o(vld[4]), .lockup_o(lck[4]));

    int checks = 0;
    int errors = 0;

    int unsigned wid [5] = '{8, 1, 8, 1, 8};
    bit          gal [5] = '{0, 0, 1, 1, 0};

    logic [63:0] exp_data  [5];
    logic        exp_valid [5];
    logic        exp_lock  [5];
    logic [7:0]  m_state   [5];
    logic [7:0]  m_taps    [5];

    bit   rec;
    logic q0 [$];
    logic q1 [$];
    logic ref_bits [255];

    function automatic logic [63:0] obs_data(input int i);
        case (i)
            0:       return {56'b0, d0};
            1:       return {63'b0, d1};
            2:       return {56'b0, d2};
            3:       return {63'b0, d3};
            default: return {56'b0, d4};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: the register as an integer; output the LSB, then shift
    // right and either insert the tap parity at the top or XOR in the taps.
    task automatic model_word(input logic [7:0] s_in, input logic [7:0] t, input bit g,
                              input int unsigned w, output logic [63:0] word, output logic [7:0] s_out);
        int unsigned s;
        int unsigned b;
        int unsigned fb;
        s    = s_in;
        word = '0;
        for (int unsigned k = 0; k < w; k++) begin
            b       = s % 2;
            word[k] = b[0];
            if (g) begin
                s = (s / 2) ^ (b * t);
            end else begin
                fb = $countones(s & t) % 2;
                s  = s / 2 + fb * 128;
            end
        end
        s_out = s[7:0];
    endtask

    task automatic reset_model();
        for (int i = 0; i < 5; i++) begin
            exp_data[i]  = '0;
            exp_valid[i] = 1'b0;
            m_taps[i]    = 8'h03;
            m_state[i]   = (i == 4) ? 8'h00 : 8'h01;
            exp_lock[i]  = (m_state[i] == 8'h00);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("data%0d", i), obs_data(i), exp_data[i]);
            check($sformatf("valid%0d", i), {63'b0, vld[i]}, {63'b0, exp_valid[i]});
            check($sformatf("lockup%0d", i), {63'b0, lck[i]}, {63'b0, exp_lock[i]});
        end
    endtask

    task automatic step_cycle();
        logic [63:0] w;
        logic [7:0]  s;
        for (int i = 0; i < 5; i++) begin
            if (i == 4 && load_v) begin
                exp_valid[i] = 1'b0;
                m_state[i]   = seed_v;
                m_taps[i]    = taps_v;
                exp_lock[i]  = (seed_v == 8'h00);
            end else if (!exp_valid[i] || rdy[i]) begin
                model_word(m_state[i], m_taps[i], gal[i], wid[i], w, s);
                exp_data[i]  = w;
                exp_valid[i] = 1'b1;
                m_state[i]   = s;
                exp_lock[i]  = (s == 8'h00);
            end
        end
        @(negedge clk);
        load_n = 1'($urandom);
        taps_n = 8'($urandom);
        seed_n = 8'($urandom);
        check_all();
        if (rec) begin
            for (int b = 0; b < 8; b++) q0.push_back(d0[b]);
            q1.push_back(d1);
        end
    endtask

    initial begin
        logic [63:0] w;
        logic [7:0]  s;
        logic [63:0] saved;

        reset_i = 1'b1;
        rdy     = '1;
        load_v  = 1'b0;
        taps_v  = '0;
        seed_v  = '0;
        load_n  = 1'b0;
        taps_n  = '0;
        seed_n  = '0;
        rec     = 1'b0;
        reset_model();

        s = 8'h01;
        for (int i = 0; i < 255; i++) begin
            model_word(s, 8'h03, 1'b0, 1, w, s);
            ref_bits[i] = w[0];
        end

        @(negedge clk);
        check_all();
        reset_i = 1'b0;

        // Free-running stream; W=8 and W=1 Fibonacci streams are recorded.
        rec = 1'b1;
        step_cycle();
        check("first_word_fib", {56'b0, d0}, 64'h01);
        check("first_word_gal", {56'b0, d2}, 64'hDB);
        for (int c = 0; c < 254; c++) begin
            rdy[2] = 1'($urandom);
            rdy[4] = 1'($urandom);
            load_v = (c == 10);
            taps_v = 8'hB8;
            seed_v = 8'h01;
            step_cycle();
        end
        rec = 1'b0;
        for (int i = 0; i < 255; i++) begin
            check($sformatf("stream_w8_bit%0d", i), {63'b0, q0[i]}, {63'b0, ref_bits[i]});
            check($sformatf("stream_w1_bit%0d", i), {63'b0, q1[i]}, {63'b0, ref_bits[i]});
        end

        // Backpressure on the W=8 stream
        rdy   = '1;
        step_cycle();
        saved = exp_data[0];
        rdy[0] = 1'b0;
        repeat (5) begin
            step_cycle();
            check("bp_hold_data", {56'b0, d0}, saved);
            check("bp_hold_valid", {63'b0, vld[0]}, 64'h1);
        end
        rdy[0] = 1'b1;
        step_cycle();

        // Load mid-stream under backpressure drops the pending word
        rdy[4] = 1'b0;
        load_v = 1'b1;
        taps_v = 8'hB8;
        seed_v = 8'hA5;
        step_cycle();
        check("load_drop_valid", {63'b0, vld[4]}, 64'h0);
        load_v = 1'b0;
        step_cycle();
        model_word(8'hA5, 8'hB8, 1'b0, 8, w, s);
        check("load_first_word", {56'b0, d4}, w);
        rdy[4] = 1'b1;
        repeat (4) step_cycle();

        // Load coinciding with ready
        load_v = 1'b1;
        seed_v = 8'h3C;
        step_cycle();
        load_v = 1'b0;
        repeat (3) step_cycle();

        // Zero seed locks up until reloaded
        load_v = 1'b1;
        seed_v = 8'h00;
        step_cycle();
        check("lock_set", {63'b0, lck[4]}, 64'h1);
        load_v = 1'b0;
        repeat (3) begin
            step_cycle();
            check("lock_data_zero", {56'b0, d4}, 64'h0);
        end
        load_v = 1'b1;
        seed_v = 8'h01;
        step_cycle();
        check("lock_clear", {63'b0, lck[4]}, 64'h0);

        // Held load keeps valid low
        repeat (3) step_cycle();
        load_v = 1'b0;
        step_cycle();

        // Random traffic and random reconfiguration
        repeat (300) begin
            rdy    = 5'($urandom);
            load_v = ($urandom_range(7) == 0);
            taps_v = 8'($urandom);
            seed_v = 8'($urandom);
            step_cycle();
        end
        load_v = 1'b0;
        rdy    = '1;
        step_cycle();

        // Asynchronous reset between edges
        @(posedge clk);
        #2 reset_i = 1'b1;
        #1;
        reset_model();
        check_all();
        @(negedge clk);
        reset_i = 1'b0;
        step_cycle();
        check("rst_first_word_fib", {56'b0, d0}, 64'h01);
        check("rst_first_word_gal", {56'b0, d2}, 64'hDB);
        repeat (20) step_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
